// File: rtl/jpeg_vote_pipe_if.sv
// Valid/ready bundle for jpeg_vote_pipe: vector input side and {bit, pop} result side.
interface jpeg_vote_pipe_if #(
   parameter int NUM_IN = 11,
   parameter int POP_W  = $clog2(NUM_IN + 1)
);
   logic              in_valid;
   logic              in_ready;
   logic [NUM_IN-1:0] in_data;
   logic [1:0]        in_mode;
   logic              out_valid;
   logic              out_ready;
   logic              out_bit;
   logic [POP_W-1:0]  out_pop;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_bit, out_pop
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_bit, out_pop
   );
endinterface

// File: rtl/jpeg_vote_pipe.sv
// Pipelined NUM_IN-input vote/reduction with backpressure and a hit counter.
// Optional JPEG_VOTE_SAT_CNT_EN: saturating hit_count plus sticky sat_flag.
module jpeg_vote_pipe #(
   parameter int NUM_IN     = 11,
   parameter int THRESH     = (NUM_IN + 1) / 2,
   parameter int PIPE_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   jpeg_vote_pipe_if.slave    bus,
   input  logic               clr_cnt,
   output logic [CNT_W-1:0]   hit_count
`ifdef JPEG_VOTE_SAT_CNT_EN
   ,
   output logic               sat_flag
`endif
);
   localparam int                POP_W    = $clog2(NUM_IN + 1);
   localparam logic [POP_W-1:0]  THRESH_P = POP_W'(THRESH);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic [1:0] {
      MODE_MAJ = 2'b00,
      MODE_PAR = 2'b01,
      MODE_ANY = 2'b10,
      MODE_ALL = 2'b11
   } mode_e;

   logic [PIPE_DEPTH:1] vld;
   logic [PIPE_DEPTH:1] can_load;
   logic                dec_q [1:PIPE_DEPTH];
   logic [POP_W-1:0]    pop_q [1:PIPE_DEPTH];

   logic                dec_s0;
   logic [POP_W-1:0]    pop_s0;
   logic                hit;

   always_comb begin
      pop_s0 = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         pop_s0 = pop_s0 + POP_W'(bus.in_data[i]);
      end
      dec_s0 = 1'b0;
      case (mode_e'(bus.in_mode))
         MODE_MAJ: dec_s0 = (pop_s0 >= THRESH_P);
         MODE_PAR: dec_s0 = ^bus.in_data;
         MODE_ANY: dec_s0 = |bus.in_data;
         MODE_ALL: dec_s0 = &bus.in_data;
         default:  dec_s0 = 1'b0;
      endcase
   end

   // A stage may load when empty or when its contents move on this cycle;
   // this ripples back from out_ready so a full pipe still streams.
   always_comb begin
      can_load             = '0;
      can_load[PIPE_DEPTH] = !vld[PIPE_DEPTH] || bus.out_ready;
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
         can_load[k] = !vld[k] || can_load[k+1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int k = 1; k <= PIPE_DEPTH; k++) begin
            dec_q[k] <= 1'b0;
            pop_q[k] <= '0;
         end
      end else begin
         if (can_load[1]) begin
            vld[1] <= bus.in_valid;
            if (bus.in_valid) begin
               dec_q[1] <= dec_s0;
               pop_q[1] <= pop_s0;
            end
         end
         for (int k = 2; k <= PIPE_DEPTH; k++) begin
            if (can_load[k]) begin
               vld[k] <= vld[k-1];
               if (vld[k-1]) begin
                  dec_q[k] <= dec_q[k-1];
                  pop_q[k] <= pop_q[k-1];
               end
            end
         end
      end
   end

   assign bus.in_ready  = can_load[1];
   assign bus.out_valid = vld[PIPE_DEPTH];
   assign bus.out_bit   = dec_q[PIPE_DEPTH];
   assign bus.out_pop   = pop_q[PIPE_DEPTH];

   assign hit = vld[PIPE_DEPTH] && bus.out_ready && dec_q[PIPE_DEPTH];

   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         hit_count <= '0;
      end else if (hit) begin
`ifdef JPEG_VOTE_SAT_CNT_EN
         if (hit_count != CNT_MAX) begin
            hit_count <= hit_count + 1'b1;
         end
`else
         hit_count <= hit_count + 1'b1;
`endif
      end
   end

`ifdef JPEG_VOTE_SAT_CNT_EN
   // Raised on the same edge that the counter reaches all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         sat_flag <= 1'b0;
      end else if (hit && (hit_count == CNT_MAX - 1'b1)) begin
         sat_flag <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_jpeg_vote_pipe.sv
// Scoreboard bench for jpeg_vote_pipe; a second CNT_W=2 instance mirrors the stimulus.
module tb_jpeg_vote_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        clr_cnt;
   logic [15:0] hit_count;
   logic [1:0]  hit_count2;
`ifdef JPEG_VOTE_SAT_CNT_EN
   logic        sat_flag;
   logic        sat_flag2;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [4:0]  sb [$];

   jpeg_vote_pipe_if #(.NUM_IN(11)) bus  ();
   jpeg_vote_pipe_if #(.NUM_IN(11)) bus2 ();

   assign bus2.in_valid  = bus.in_valid;
   assign bus2.in_data   = bus.in_data;
   assign bus2.in_mode   = bus.in_mode;
   assign bus2.out_ready = bus.out_ready;

   jpeg_vote_pipe #(.NUM_IN(11), .PIPE_DEPTH(2), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .clr_cnt   (clr_cnt),
      .hit_count (hit_count)
`ifdef JPEG_VOTE_SAT_CNT_EN
      ,
      .sat_flag  (sat_flag)
`endif
   );

   jpeg_vote_pipe #(.NUM_IN(11), .PIPE_DEPTH(2), .CNT_W(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus2.slave),
      .clr_cnt   (clr_cnt),
      .hit_count (hit_count2)
`ifdef JPEG_VOTE_SAT_CNT_EN
      ,
      .sat_flag  (sat_flag2)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] model(input logic [10:0] d, input logic [1:0] m);
      int   p;
      logic b;
      p = $countones(d);
      case (m)
         2'b00:   b = (p >= 6);
         2'b01:   b = ^d;
         2'b10:   b = |d;
         default: b = &d;
      endcase
      return {b, 4'(p)};
   endfunction

   // One clock: drive at posedge+1, sample at negedge, return at next posedge+1.
   task automatic step(input logic v, input logic [10:0] d, input logic [1:0] m,
                       input logic ordy, input logic clr, input logic r,
                       output logic in_hs, output logic out_hs,
                       output logic ob, output logic [3:0] op);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_mode   = m;
      bus.out_ready = ordy;
      clr_cnt       = clr;
      rst           = r;
      @(negedge clk);
      in_hs  = v && bus.in_ready && !r;
      out_hs = bus.out_valid && ordy && !r;
      ob     = bus.out_bit;
      op     = bus.out_pop;
      if (in_hs) sb.push_back(model(d, m));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic ih, oh, ob;
      logic [3:0] op;
      step(1'b0, 11'h0, 2'b00, 1'b1, 1'b0, 1'b1, ih, oh, ob, op);
      step(1'b0, 11'h0, 2'b00, 1'b1, 1'b0, 1'b1, ih, oh, ob, op);
      rst = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      n_checks++; if (bus.out_bit !== 1'b0) begin n_fail++; $display("FAIL reset_out_bit got=%b exp=0", bus.out_bit); end
      n_checks++; if (bus.out_pop !== 4'd0) begin n_fail++; $display("FAIL reset_out_pop got=%0d exp=0", bus.out_pop); end
      n_checks++; if (hit_count !== 16'd0) begin n_fail++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_latency();
      logic ih, oh, ob, seen;
      logic [3:0] op;
      logic [4:0] e;
      logic [10:0] vecs [2];
      vecs[0] = 11'b00000111111;
      vecs[1] = 11'b00000011111;
      for (int n = 0; n < 2; n++) begin
         step(1'b1, vecs[n], 2'b00, 1'b1, 1'b0, 1'b0, ih, oh, ob, op);
         n_checks++; if (ih !== 1'b1) begin n_fail++; $display("FAIL lat_accept got=%b exp=1", ih); end
         seen = 1'b0;
         for (int k = 1; k <= 8 && !seen; k++) begin
            step(1'b0, 11'h0, 2'b00, 1'b1, 1'b0, 1'b0, ih, oh, ob, op);
            if (oh) begin
               seen = 1'b1;
               n_checks++; if (k != 2) begin n_fail++; $display("FAIL lat_cycles got=%0d exp=2", k); end
               e = sb.pop_front();
               n_checks++; if ({ob, op} !== e) begin n_fail++; $display("FAIL lat_result got=%b/%0d exp=%b/%0d", ob, op, e[4], e[3:0]); end
            end
         end
         n_checks++; if (!seen) begin n_fail++; $display("FAIL lat_timeout got=no_output exp=output"); end
      end
      n_checks++; if ({sb.size() == 0} !== 1'b1) begin n_fail++; $display("FAIL lat_sb_empty got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_modes();
      logic ih, oh, ob;
      logic [3:0] op;
      logic [4:0] e;
      logic [10:0] d;
      int sent = 0, outs = 0;
      for (int c = 0; c < 30 && outs < 8; c++) begin
         d = (sent < 4) ? 11'b10000000001 : 11'h7FF;
         step(sent < 8, d, 2'(sent % 4), 1'b1, 1'b0, 1'b0, ih, oh, ob, op);
         if (ih) sent++;
         if (oh) begin
            outs++;
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL modes_unexpected got=%b/%0d exp=none", ob, op); end
            else begin
               e = sb.pop_front();
               if ({ob, op} !== e) begin n_fail++; $display("FAIL modes_result got=%b/%0d exp=%b/%0d", ob, op, e[4], e[3:0]); end
            end
         end
      end
      n_checks++; if (outs != 8) begin n_fail++; $display("FAIL modes_count got=%0d exp=8", outs); end
   endtask

   task automatic test_back_to_back();
      logic ih, oh, ob;
      logic [3:0] op;
      logic [4:0] e;
      logic [10:0] vecs [6];
      logic [1:0]  modes [6];
      int idx = 0, outs = 0, gaps = 0;
      vecs[0] = 11'h7FF; modes[0] = 2'b00;
      vecs[1] = 11'h001; modes[1] = 2'b01;
      vecs[2] = 11'h000; modes[2] = 2'b10;
      vecs[3] = 11'h3F0; modes[3] = 2'b00;
      vecs[4] = 11'h7FE; modes[4] = 2'b11;
      vecs[5] = 11'h555; modes[5] = 2'b01;
      for (int c = 0; c < 5; c++) begin
         step(1'b1, vecs[idx], modes[idx], 1'b0, 1'b0, 1'b0, ih, oh, ob, op);
         if (ih) idx++;
      end
      n_checks++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=2", idx); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
      n_checks++; if ({ob, op} !== sb[0]) begin n_fail++; $display("FAIL bp_stall_hold got=%b/%0d exp=%b/%0d", ob, op, sb[0][4], sb[0][3:0]); end
      for (int c = 0; c < 20 && outs < 6; c++) begin
         step(idx < 6, vecs[idx % 6], modes[idx % 6], 1'b1, 1'b0, 1'b0, ih, oh, ob, op);
         if (ih) idx++;
         if (oh) begin
            outs++;
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL bp_unexpected got=%b/%0d exp=none", ob, op); end
            else begin
               e = sb.pop_front();
               if ({ob, op} !== e) begin n_fail++; $display("FAIL bp_result got=%b/%0d exp=%b/%0d", ob, op, e[4], e[3:0]); end
            end
         end else if (outs > 0) begin
            gaps++;
         end
      end
      n_checks++; if (outs != 6) begin n_fail++; $display("FAIL bp_out_count got=%0d exp=6", outs); end
      n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL bp_gaps got=%0d exp=0", gaps); end
   endtask

   task automatic test_counter();
      logic ih, oh, ob;
      logic [3:0] op;
      logic [4:0] e;
      int sent = 0;
      step(1'b0, 11'h0, 2'b00, 1'b1, 1'b1, 1'b0, ih, oh, ob, op);
      n_checks++; if (hit_count !== 16'd0) begin n_fail++; $display("FAIL cnt_clear got=%0d exp=0", hit_count); end
      for (int c = 0; c < 20 && (sent < 5 || sb.size() > 0); c++) begin
         step(sent < 5, 11'h7FF, 2'b10, 1'b1, 1'b0, 1'b0, ih, oh, ob, op);
         if (ih) sent++;
         if (oh) void'(sb.pop_front());
      end
      n_checks++; if (hit_count !== 16'd5) begin n_fail++; $display("FAIL cnt_five got=%0d exp=5", hit_count); end
      step(1'b1, 11'h7FF, 2'b10, 1'b1, 1'b0, 1'b0, ih, oh, ob, op);
      step(1'b0, 11'h0, 2'b00, 1'b1, 1'b0, 1'b0, ih, oh, ob, op);
      step(1'b0, 11'h0, 2'b00, 1'b1, 1'b1, 1'b0, ih, oh, ob, op);
      n_checks++; if ({oh, ob} !== 2'b11) begin n_fail++; $display("FAIL cnt_sixth_hit got=%b%b exp=11", oh, ob); end
      if (oh && sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++; if ({ob, op} !== e) begin n_fail++; $display("FAIL cnt_result got=%b/%0d exp=%b/%0d", ob, op, e[4], e[3:0]); end
      end
      n_checks++; if (hit_count !== 16'd0) begin n_fail++; $display("FAIL cnt_clr_priority got=%0d exp=0", hit_count); end
      clr_cnt = 1'b0;
      sb.delete();
   endtask

   task automatic test_overflow();
      logic ih, oh, ob;
      logic [3:0] op;
      int sent = 0;
      step(1'b0, 11'h0, 2'b00, 1'b1, 1'b1, 1'b0, ih, oh, ob, op);
      for (int c = 0; c < 20 && (sent < 5 || sb.size() > 0); c++) begin
         step(sent < 5, 11'h7FF, 2'b11, 1'b1, 1'b0, 1'b0, ih, oh, ob, op);
         if (ih) sent++;
         if (oh) void'(sb.pop_front());
`ifdef JPEG_VOTE_SAT_CNT_EN
         n_checks++; if (sat_flag2 !== (hit_count2 == 2'd3)) begin n_fail++; $display("FAIL ovf_sat_timing got=%b cnt=%0d", sat_flag2, hit_count2); end
`endif
      end
      n_checks++; if (hit_count !== 16'd5) begin n_fail++; $display("FAIL ovf_wide_count got=%0d exp=5", hit_count); end
`ifdef JPEG_VOTE_SAT_CNT_EN
      n_checks++; if (hit_count2 !== 2'd3) begin n_fail++; $display("FAIL ovf_sat_count got=%0d exp=3", hit_count2); end
      n_checks++; if (sat_flag2 !== 1'b1) begin n_fail++; $display("FAIL ovf_sat_flag got=%b exp=1", sat_flag2); end
      n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_wide_sat_flag got=%b exp=0", sat_flag); end
      step(1'b0, 11'h0, 2'b00, 1'b1, 1'b1, 1'b0, ih, oh, ob, op);
      n_checks++; if ({sat_flag2, hit_count2} !== 3'b000) begin n_fail++; $display("FAIL ovf_clr got=%b/%0d exp=0/0", sat_flag2, hit_count2); end
`else
      n_checks++; if (hit_count2 !== 2'd1) begin n_fail++; $display("FAIL ovf_wrap_count got=%0d exp=1", hit_count2); end
`endif
      clr_cnt = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic ih, oh, ob;
      logic [3:0] op;
      step(1'b1, 11'h7FF, 2'b10, 1'b1, 1'b0, 1'b0, ih, oh, ob, op);
      for (int c = 0; c < 3; c++) step(1'b0, 11'h0, 2'b00, 1'b1, 1'b0, 1'b0, ih, oh, ob, op);
      sb.delete();
      for (int c = 0; c < 4; c++) step(1'b1, 11'h7FF, 2'b10, 1'b0, 1'b0, 1'b0, ih, oh, ob, op);
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full got=%b exp=0", bus.in_ready); end
      n_checks++; if (hit_count === 16'd0) begin n_fail++; $display("FAIL rmid_pre_count got=%0d exp=nonzero", hit_count); end
      step(1'b1, 11'h7FF, 2'b10, 1'b1, 1'b0, 1'b1, ih, oh, ob, op);
      rst = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got=%b exp=0", bus.out_valid); end
      n_checks++; if (hit_count !== 16'd0) begin n_fail++; $display("FAIL rmid_hit_count got=%0d exp=0", hit_count); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got=%b exp=1", bus.in_ready); end
      sb.delete();
   endtask

   task automatic test_random();
      logic ih, oh, ob;
      logic [3:0] op;
      logic [4:0] e;
      logic [15:0] exp_hits = 16'd0;
      int outs = 0;
      step(1'b0, 11'h0, 2'b00, 1'b1, 1'b1, 1'b0, ih, oh, ob, op);
      for (int c = 0; c < 400; c++) begin
         step(c < 360 && ($urandom_range(0, 3) != 0), 11'($urandom), 2'($urandom),
              (c >= 360) || ($urandom_range(0, 3) != 0), 1'b0, 1'b0, ih, oh, ob, op);
         if (oh) begin
            outs++;
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL rnd_unexpected got=%b/%0d exp=none", ob, op); end
            else begin
               e = sb.pop_front();
               if (e[4]) exp_hits = exp_hits + 16'd1;
               if ({ob, op} !== e) begin n_fail++; $display("FAIL rnd_result got=%b/%0d exp=%b/%0d", ob, op, e[4], e[3:0]); end
            end
         end
      end
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rnd_drain got=%0d exp=0", sb.size()); end
      n_checks++; if (outs < 50) begin n_fail++; $display("FAIL rnd_traffic got=%0d exp=>=50", outs); end
      n_checks++; if (hit_count !== exp_hits) begin n_fail++; $display("FAIL rnd_hit_count got=%0d exp=%0d", hit_count, exp_hits); end
   endtask

   initial begin
      rst = 1'b1;
      clr_cnt = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_mode = 2'b00;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_latency();
      test_modes();
      test_back_to_back();
      test_counter();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
